execute_p: RTL

Parametrised successor to the bexkat1 execute stage. Sits between register fetch and memory/writeback. Decodes the 64-bit instruction word, drives `alu_comb` and `intcalc`, updates condition codes and resolves branches/jumps. Adds per-stage valid tracking, a downstream back-pressure input, a pipeline flush, and a configurable integer-unit latency.

---
 rtl/execute_p_pkg.sv | 56 +++++
 rtl/alu_comb.sv | 55 +++++
 rtl/exec_branch_eval.sv | 31 +++
 rtl/intcalc.sv | 29 ++
 rtl/execute_p.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/execute_p_pkg.sv
// Shared bexkat1 definitions: instruction type codes, ALU/INT function codes
// and branch-condition op encodings used by the execute stage.
package bexkat1Def;

  // Instruction type field ir[31:28]
  localparam logic [3:0] T_INH    = 4'h0;
  localparam logic [3:0] T_PUSH   = 4'h1;
  localparam logic [3:0] T_POP    = 4'h2;
  localparam logic [3:0] T_CMP    = 4'h3;
  localparam logic [3:0] T_MOV    = 4'h4;
  localparam logic [3:0] T_INTU   = 4'h5;
  localparam logic [3:0] T_ALU    = 4'h6;
  localparam logic [3:0] T_INT    = 4'h7;
  localparam logic [3:0] T_BRANCH = 4'h8;
  localparam logic [3:0] T_JUMP   = 4'h9;
  localparam logic [3:0] T_LOAD   = 4'ha;
  localparam logic [3:0] T_STORE  = 4'hb;
  localparam logic [3:0] T_LDI    = 4'hc;

  // T_INH op that halts the core
  localparam logic [3:0] INH_HALT = 4'h4;

  typedef enum logic [2:0] {
    ALU_AND     = 3'd0,
    ALU_OR      = 3'd1,
    ALU_ADD     = 3'd2,
    ALU_SUB     = 3'd3,
    ALU_LSHIFT  = 3'd4,
    ALU_RSHIFTA = 3'd5,
    ALU_RSHIFTL = 3'd6,
    ALU_XOR     = 3'd7
  } alufunc_t;

  typedef enum logic [3:0] {
    INT_MUL  = 4'd0,
    INT_DIV  = 4'd1,
    INT_MOD  = 4'd2,
    INT_MULU = 4'd3,
    INT_DIVU = 4'd4,
    INT_MODU = 4'd5
  } intfunc_t;

  // Branch condition op encodings; ccr = {ltu, lt, eq}
  localparam logic [3:0] BR_ALWAYS = 4'h0;
  localparam logic [3:0] BR_EQ     = 4'h1;
  localparam logic [3:0] BR_NE     = 4'h2;
  localparam logic [3:0] BR_GTU    = 4'h3;
  localparam logic [3:0] BR_GT     = 4'h4;
  localparam logic [3:0] BR_GE     = 4'h5;
  localparam logic [3:0] BR_LE     = 4'h6;
  localparam logic [3:0] BR_LT     = 4'h7;
  localparam logic [3:0] BR_GEU    = 4'h8;
  localparam logic [3:0] BR_LTU    = 4'h9;
  localparam logic [3:0] BR_LEU    = 4'ha;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU with carry/borrow, negative, overflow and zero flags.
// Ports: in1_i/in2_i operands, func_i function, out_o result, c/n/v/z flags.
module alu_comb
  import bexkat1Def::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] in1_i,
  input  logic [DATA_W-1:0] in2_i,
  input  alufunc_t          func_i,
  output logic [DATA_W-1:0] out_o,
  output logic              c_o,
  output logic              n_o,
  output logic              v_o,
  output logic              z_o
);
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [SH_W-1:0]   sh;

  assign sh = in2_i[SH_W-1:0];

  always_comb begin
    sum   = {1'b0, in1_i} + {1'b0, in2_i};
    diff  = {1'b0, in1_i} - {1'b0, in2_i};
    out_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    case (func_i)
      ALU_AND:     out_o = in1_i & in2_i;
      ALU_OR:      out_o = in1_i | in2_i;
      ALU_ADD: begin
        out_o = sum[DATA_W-1:0];
        c_o   = sum[DATA_W];
        v_o   = (in1_i[DATA_W-1] == in2_i[DATA_W-1]) && (out_o[DATA_W-1] != in1_i[DATA_W-1]);
      end
      // c is the borrow, so c = 1 means in1 < in2 unsigned
      ALU_SUB: begin
        out_o = diff[DATA_W-1:0];
        c_o   = diff[DATA_W];
        v_o   = (in1_i[DATA_W-1] != in2_i[DATA_W-1]) && (out_o[DATA_W-1] != in1_i[DATA_W-1]);
      end
      ALU_LSHIFT:  out_o = in1_i << sh;
      ALU_RSHIFTA: out_o = $signed(in1_i) >>> sh;
      ALU_RSHIFTL: out_o = in1_i >> sh;
      ALU_XOR:     out_o = in1_i ^ in2_i;
      default:     out_o = '0;
    endcase
    n_o = out_o[DATA_W-1];
    z_o = (out_o == '0);
  end

endmodule

// File: rtl/exec_branch_eval.sv
// Branch condition evaluation: op_i and ccr_i = {ltu, lt, eq} -> taken_o.
module exec_branch_eval
  import bexkat1Def::*;
(
  input  logic [3:0] op_i,
  input  logic [2:0] ccr_i,
  output logic       taken_o
);
  logic ltu, lt, eq;

  assign {ltu, lt, eq} = ccr_i;

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      BR_ALWAYS: taken_o = 1'b1;
      BR_EQ:     taken_o = eq;
      BR_NE:     taken_o = !eq;
      BR_GTU:    taken_o = !(ltu | eq);
      BR_GT:     taken_o = !(lt | eq);
      BR_GE:     taken_o = !lt;
      BR_LE:     taken_o = lt | eq;
      BR_LT:     taken_o = lt;
      BR_GEU:    taken_o = !ltu;
      BR_LTU:    taken_o = ltu;
      BR_LEU:    taken_o = ltu | eq;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/intcalc.sv
// Combinational integer multiply/divide/modulo unit; divide by zero yields 0.
// Ports: in1_i/in2_i operands, func_i function, out_o result.
module intcalc
  import bexkat1Def::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] in1_i,
  input  logic [DATA_W-1:0] in2_i,
  input  intfunc_t          func_i,
  output logic [DATA_W-1:0] out_o
);
  logic div0;

  assign div0 = (in2_i == '0);

  always_comb begin
    out_o = '0;
    case (func_i)
      INT_MUL, INT_MULU: out_o = in1_i * in2_i;
      INT_DIV:  out_o = div0 ? '0 : DATA_W'($signed(in1_i) / $signed(in2_i));
      INT_MOD:  out_o = div0 ? '0 : DATA_W'($signed(in1_i) % $signed(in2_i));
      INT_DIVU: out_o = div0 ? '0 : in1_i / in2_i;
      INT_MODU: out_o = div0 ? '0 : in1_i % in2_i;
      default:  out_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_p.sv
// bexkat1 execute stage: decode, ALU/INT, condition codes, branch/jump resolve,
// with valid tracking, back-pressure, flush and multi-cycle INT countdown.
// Ports: clk_i/rst_i; ir_i, pc_i, valid_i, reg_data1/2_i, reg_write_i from fetch;
// stall_i, flush_i control; registered result/ccr/halt/ir/pc/pc_set/valid outputs,
// combinational stall_o back to upstream.
module execute_p
  import bexkat1Def::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INT_DELAY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [63:0]       ir_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] reg_data1_i,
  input  logic [DATA_W-1:0] reg_data2_i,
  input  logic [1:0]        reg_write_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] reg_data1_o,
  output logic [1:0]        reg_write_o,
  output logic [2:0]        ccr_o,
  output logic              halt_o,
  output logic              stall_o,
  output logic [63:0]       ir_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              pc_set_o,
  output logic              valid_o
);
  localparam int unsigned CNT_W     = (INT_DELAY < 2) ? 1 : $clog2(INT_DELAY + 1);
  localparam bit          HAS_DELAY = (INT_DELAY != 0);

  logic [3:0]        ir_type, ir_op;
  logic              ir_size;
  logic [DATA_W-1:0] sval, uval, ext, sval4;
  logic              is_int;

  assign ir_type = ir_i[31:28];
  assign ir_op   = ir_i[27:24];
  assign ir_size = ir_i[0];
  assign sval    = {{(DATA_W-15){ir_i[15]}}, ir_i[15:1]};
  assign uval    = DATA_W'(ir_i[15:1]);
  assign ext     = DATA_W'(ir_i[63:32]);
  assign sval4   = sval << 2;
  assign is_int  = (ir_type == T_INT) || (ir_type == T_INTU);

  // Operand and function selection for the ALU and integer unit
  logic [DATA_W-1:0] alu_in2, alu_out, int_in2, int_out;
  alufunc_t          alu_func;
  intfunc_t          int_func;
  logic              alu_c, alu_n, alu_v, alu_z;

  always_comb begin
    alu_in2  = reg_data2_i;
    alu_func = ALU_ADD;
    int_in2  = reg_data2_i;
    int_func = intfunc_t'(ir_op);
    case (ir_type)
      T_ALU: begin
        alu_func = alufunc_t'(ir_op[2:0]);
        if (ir_op[3]) alu_in2 = sval;
      end
      T_CMP:  alu_func = ALU_SUB;
      T_JUMP: alu_in2  = sval4;
      T_INT: begin
        if (ir_op[3]) begin
          int_in2  = sval4;
          int_func = intfunc_t'({1'b0, ir_op[2:0]});
        end
      end
      default: ;
    endcase
  end

  alu_comb #(.DATA_W(DATA_W)) u_alu (
    .in1_i (reg_data1_i),
    .in2_i (alu_in2),
    .func_i(alu_func),
    .out_o (alu_out),
    .c_o   (alu_c),
    .n_o   (alu_n),
    .v_o   (alu_v),
    .z_o   (alu_z)
  );

  intcalc #(.DATA_W(DATA_W)) u_int (
    .in1_i (reg_data1_i),
    .in2_i (int_in2),
    .func_i(int_func),
    .out_o (int_out)
  );

  logic br_taken;

  exec_branch_eval u_br (
    .op_i   (ir_op),
    .ccr_i  (ccr_o),
    .taken_o(br_taken)
  );

  // Result and next-PC selection
  logic [DATA_W-1:0] result, next_pc;

  always_comb begin
    result = alu_out;
    case (ir_type)
      T_INT, T_INTU:   result = int_out;
      T_LOAD, T_STORE: result = ir_size ? ext : sval4 + reg_data2_i;
      T_LDI:           result = ir_size ? ext : uval;
      T_MOV:           result = reg_data1_i;
      default: ;
    endcase
  end

  always_comb begin
    next_pc = pc_i;
    if (ir_type == T_BRANCH)    next_pc = pc_i + sval4;
    else if (ir_type == T_JUMP) next_pc = ir_size ? ext : alu_out;
  end

  // INT countdown control; the result is captured when the count reaches 1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_start, fire;

  assign int_start = valid_i && is_int && !stall_i && !flush_i && (cnt_q == '0) && HAS_DELAY;
  assign fire      = valid_i && !stall_i && !flush_i &&
                     (!is_int || !HAS_DELAY || (cnt_q == CNT_W'(1)));
  assign stall_o   = stall_i || int_start || (cnt_q > CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)             cnt_d = '0;
    else if (stall_i)        cnt_d = cnt_q;
    else if (int_start)      cnt_d = CNT_W'(INT_DELAY);
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  // Output register next-state
  logic [DATA_W-1:0] result_d, reg_data1_d, pc_d;
  logic [1:0]        reg_write_d;
  logic [2:0]        ccr_d;
  logic              halt_d, pc_set_d, valid_d;
  logic [63:0]       ir_d;

  always_comb begin
    result_d    = result_o;
    reg_data1_d = reg_data1_o;
    reg_write_d = reg_write_o;
    ccr_d       = ccr_o;
    halt_d      = halt_o;
    ir_d        = ir_o;
    pc_d        = pc_o;
    pc_set_d    = pc_set_o;
    valid_d     = valid_o;
    if (flush_i || (!stall_i && !fire)) begin
      // Flush, bubble or INT still counting: nothing valid leaves this cycle
      valid_d     = 1'b0;
      reg_write_d = 2'b00;
      pc_set_d    = 1'b0;
    end else if (fire) begin
      result_d    = result;
      reg_data1_d = reg_data1_i;
      reg_write_d = reg_write_i;
      ir_d        = ir_i;
      pc_d        = next_pc;
      valid_d     = 1'b1;
      pc_set_d    = (ir_type == T_JUMP) || ((ir_type == T_BRANCH) && br_taken);
      if (ir_type == T_CMP) ccr_d = {alu_c, alu_n ^ alu_v, alu_z};
      if ((ir_type == T_INH) && (ir_op == INH_HALT)) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      result_o    <= '0;
      reg_data1_o <= '0;
      reg_write_o <= '0;
      ccr_o       <= '0;
      halt_o      <= 1'b0;
      ir_o        <= '0;
      pc_o        <= '0;
      pc_set_o    <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      result_o    <= result_d;
      reg_data1_o <= reg_data1_d;
      reg_write_o <= reg_write_d;
      ccr_o       <= ccr_d;
      halt_o      <= halt_d;
      ir_o        <= ir_d;
      pc_o        <= pc_d;
      pc_set_o    <= pc_set_d;
      valid_o     <= valid_d;
    end
  end

endmodule
